// File: rtl/vx_lane_sequencer.sv
// ---------------------------------------------------------------------------
// vx_lane_sequencer
//
// Breaks a per-warp active-lane mask into beats of at most BATCH lanes for a
// narrow downstream resource (shared LSU port, SFU, ...). Each beat holds the
// lowest-numbered lanes of the request that have not been issued yet. Only
// one request is in flight. The next request is accepted in the same cycle
// that the last beat of the current one is consumed, so back-to-back
// requests run without a bubble.
//
// Parameters
//   NUM_LANES : lanes per request (>= 1)
//   BATCH     : maximum lanes per output beat (1 .. NUM_LANES)
//   TAG_WIDTH : width of the opaque request tag (>= 1)
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   in_valid/in_ready : request handshake. in_ready depends combinationally
//                       on out_ready.
//   in_mask, in_tag   : lanes to issue and the request tag
//   out_valid/ready   : beat handshake
//   out_mask          : lanes in this beat (a subset of the request mask)
//   out_count         : popcount of out_mask
//   out_tag           : tag of the owning request
//   out_last          : marks the final beat of the request
// ---------------------------------------------------------------------------
module vx_lane_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int BATCH     = 1,
    parameter int TAG_WIDTH = 8,
    localparam int CNT_W    = $clog2(BATCH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [NUM_LANES-1:0] in_mask,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [NUM_LANES-1:0] out_mask,
    output logic [CNT_W-1:0]     out_count,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_last,
    input  logic                 out_ready
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 state_q,     state_d;
    logic [NUM_LANES-1:0]   rem_mask_q,  rem_mask_d;
    logic [TAG_WIDTH-1:0]   tag_q,       tag_d;
    logic [NUM_LANES-1:0]   out_mask_q,  out_mask_d;
    logic [CNT_W-1:0]       out_count_q, out_count_d;
    logic                   out_last_q,  out_last_d;

    // Batch-selection datapath
    logic [NUM_LANES-1:0]   sel_src;
    logic [NUM_LANES-1:0]   sel_left;
    logic [NUM_LANES-1:0]   sel_excl;
    logic [NUM_LANES-1:0]   sel_pick;
    logic [NUM_LANES-1:0]   sel_batch;
    logic [CNT_W-1:0]       sel_count;
    logic                   sel_last;

    logic                   beat_fire;

    assign out_valid = (state_q == S_BUSY);
    assign beat_fire = out_valid && out_ready;
    assign in_ready  = (state_q == S_IDLE) || (beat_fire && out_last_q);

    // A new request is the source either when idle or when the current
    // request's last beat leaves. In every other case the source is the set
    // of lanes that are still outstanding.
    assign sel_src = ((state_q == S_IDLE) || out_last_q) ? in_mask : rem_mask_q;

    // Find-first chain. Each stage keeps the single lowest set lane of what
    // is left: src & ~exclusive_prefix_or(src). It then removes that lane for
    // the next stage. Stages that find no lane contribute nothing, so the
    // count equals the number of stages that found a lane.
    always_comb begin
        sel_left  = sel_src;
        sel_excl  = '0;
        sel_pick  = '0;
        sel_batch = '0;
        sel_count = '0;
        for (int b = 0; b < BATCH; b++) begin
            sel_excl = '0;
            for (int l = 1; l < NUM_LANES; l++) begin
                sel_excl[l] = sel_excl[l-1] | sel_left[l-1];
            end
            sel_pick  = sel_left & ~sel_excl;
            sel_batch = sel_batch | sel_pick;
            sel_count = sel_count + CNT_W'(|sel_pick);
            sel_left  = sel_left & ~sel_pick;
        end
        sel_last = (sel_left == '0);
    end

    // Next-state logic and beat loading
    always_comb begin
        state_d     = state_q;
        rem_mask_d  = rem_mask_q;
        tag_d       = tag_q;
        out_mask_d  = out_mask_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    out_mask_d  = sel_batch;
                    out_count_d = sel_count;
                    out_last_d  = sel_last;
                    rem_mask_d  = sel_left;
                    tag_d       = in_tag;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (out_ready) begin
                    if (!out_last_q || in_valid) begin
                        // Either the next beat of this request, or the first
                        // beat of a new request that follows without a gap.
                        out_mask_d  = sel_batch;
                        out_count_d = sel_count;
                        out_last_d  = sel_last;
                        rem_mask_d  = sel_left;
                        if (out_last_q) begin
                            tag_d = in_tag;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_mask_q  <= '0;
            tag_q       <= '0;
            out_mask_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_mask_q  <= rem_mask_d;
            tag_q       <= tag_d;
            out_mask_q  <= out_mask_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_mask  = out_mask_q;
    assign out_count = out_count_q;
    assign out_tag   = tag_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_vx_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vx_lane_sequencer
//
// Runs several configurations of vx_lane_sequencer side by side:
// (lanes, batch) = (4,1), (4,2), (4,4) and (8,3). Each one has its own
// driver, ready generator and monitor. When a request is accepted, the
// driver pushes the expected beats into a queue. It builds them from the
// request by taking the set lanes in ascending order and cutting them into
// groups of BATCH. The monitor pops and compares one entry on every beat
// handshake. It also checks when out_valid must be high and that the beat
// outputs hold stable while the beat is stalled.
// ---------------------------------------------------------------------------
module tb_vx_lane_sequencer;

    localparam int NCFG = 4;

    typedef struct {
        logic [7:0] mask;
        int         count;
        logic [7:0] tag;
        bit         last;
    } beat_t;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int cfg, input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, name, act, exp);
        end
    endtask

    task automatic mark_done();
        done_cnt++;
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int NL = (gi == 3) ? 8 : 4;
        localparam int BT = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 3;
        localparam int CW = $clog2(BT + 1);

        logic          rst;
        logic          in_valid;
        logic [NL-1:0] in_mask;
        logic [7:0]    in_tag;
        logic          in_ready;
        logic          out_valid;
        logic [NL-1:0] out_mask;
        logic [CW-1:0] out_count;
        logic [7:0]    out_tag;
        logic          out_last;
        logic          out_ready;

        beat_t exp_q[$];
        int    hs_cnt     = 0;
        int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

        vx_lane_sequencer #(
            .NUM_LANES (NL),
            .BATCH     (BT),
            .TAG_WIDTH (8)
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .in_valid  (in_valid),
            .in_mask   (in_mask),
            .in_tag    (in_tag),
            .in_ready  (in_ready),
            .out_valid (out_valid),
            .out_mask  (out_mask),
            .out_count (out_count),
            .out_tag   (out_tag),
            .out_last  (out_last),
            .out_ready (out_ready)
        );

        // Reference model: list the set lanes in ascending order, then cut
        // them into groups of BT. A request with no lanes still yields one
        // empty beat.
        task automatic push_expected(input logic [7:0] m, input logic [7:0] t);
            int    lanes[$];
            int    nb;
            beat_t b;
            for (int l = 0; l < NL; l++) begin
                if (m[l]) lanes.push_back(l);
            end
            nb = (lanes.size() + BT - 1) / BT;
            if (nb == 0) nb = 1;
            for (int k = 0; k < nb; k++) begin
                b.mask  = '0;
                b.count = 0;
                for (int j = k * BT; j < k * BT + BT && j < lanes.size(); j++) begin
                    b.mask[lanes[j]] = 1'b1;
                    b.count++;
                end
                b.tag  = t;
                b.last = (k == nb - 1);
                exp_q.push_back(b);
            end
        endtask

        task automatic send(input logic [7:0] m, input logic [7:0] t);
            logic [7:0] mm;
            bit         ok;
            mm       = '0;
            mm[NL-1:0] = m[NL-1:0];
            in_valid = 1'b1;
            in_mask  = m[NL-1:0];
            in_tag   = t;
            ok       = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (in_ready) begin
                    push_expected(mm, t);
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check(gi, "accept_timeout", 0, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic drain();
            bit ok;
            ready_mode = 0;
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (exp_q.size() == 0 && !out_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check(gi, "drain_timeout", 0, 1);
            @(posedge clk);
            #1;
        endtask

        task automatic check_reset_state();
            @(negedge clk);
            check(gi, "rst_out_valid", int'(out_valid), 0);
            check(gi, "rst_in_ready",  int'(in_ready),  1);
            check(gi, "rst_out_mask",  int'(out_mask),  0);
            check(gi, "rst_out_count", int'(out_count), 0);
            check(gi, "rst_out_last",  int'(out_last),  0);
            check(gi, "rst_out_tag",   int'(out_tag),   0);
        endtask

        // out_ready generator
        initial begin
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                case (ready_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(0, 3) != 0);
                    default: out_ready = 1'b0;
                endcase
            end
        end

        // Monitor / scoreboard
        initial begin
            bit         pv_acc, pv_hs, pv_last, pv_stall;
            logic [7:0] h_mask, h_tag;
            int         h_cnt;
            bit         h_last;
            beat_t      e;
            pv_acc = 0; pv_hs = 0; pv_last = 0; pv_stall = 0;
            h_mask = '0; h_tag = '0; h_cnt = 0; h_last = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    pv_acc = 0; pv_hs = 0; pv_last = 0; pv_stall = 0;
                end else begin
                    // A beat is present after an accept, after a non-final
                    // beat is consumed, and while a beat is stalled.
                    check(gi, "out_valid", int'(out_valid),
                          int'(pv_acc || (pv_hs && !pv_last) || pv_stall));
                    if (pv_stall) begin
                        check(gi, "hold_mask",  int'(out_mask),  int'(h_mask));
                        check(gi, "hold_count", int'(out_count), h_cnt);
                        check(gi, "hold_tag",   int'(out_tag),   int'(h_tag));
                        check(gi, "hold_last",  int'(out_last),  int'(h_last));
                    end
                    if (out_valid && out_ready) begin
                        hs_cnt++;
                        if (exp_q.size() == 0) begin
                            check(gi, "unexpected_beat", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            $display("cfg%0d beat mask=%0h count=%0d tag=%0h last=%0b",
                                     gi, out_mask, out_count, out_tag, out_last);
                            check(gi, "beat_mask",  int'(out_mask),  int'(e.mask));
                            check(gi, "beat_count", int'(out_count), e.count);
                            check(gi, "beat_tag",   int'(out_tag),   int'(e.tag));
                            check(gi, "beat_last",  int'(out_last),  int'(e.last));
                        end
                    end
                    pv_acc   = in_valid && in_ready;
                    pv_hs    = out_valid && out_ready;
                    pv_last  = out_last;
                    pv_stall = out_valid && !out_ready;
                    h_mask   = 8'(out_mask);
                    h_cnt    = int'(out_count);
                    h_tag    = out_tag;
                    h_last   = out_last;
                end
            end
        end

        // Driver
        initial begin
            int start;
            logic [7:0] m;
            rst      = 1'b1;
            in_valid = 1'b0;
            in_mask  = '0;
            in_tag   = '0;
            repeat (3) @(posedge clk);
            #1;
            check_reset_state();
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check(gi, "in_ready_after_reset", int'(in_ready), 1);
            @(posedge clk);
            #1;

            // Basic split
            send(8'h0B, 8'h5A);
            drain();
            // Back-to-back requests with no idle cycle between them
            send(8'h0F, 8'h11);
            send(8'h04, 8'h22);
            drain();
            // Empty request
            send(8'h00, 8'h33);
            drain();
            // Stalled first beat
            ready_mode = 2;
            send(8'h06, 8'h44);
            repeat (5) @(posedge clk);
            #1;
            ready_mode = 0;
            drain();
            // Sparse mask
            send(8'h09, 8'h55);
            drain();
            // Reset while a request is in progress
            send(8'hFF, 8'h66);
            start = hs_cnt;
            for (int c = 0; c < 50 && hs_cnt < start + 2; c++) @(posedge clk);
            #1;
            rst = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_reset_state();
            @(posedge clk);
            #1;
            send(8'h08, 8'h77);
            drain();

            // Randomised traffic
            ready_mode = 1;
            for (int r = 0; r < 40; r++) begin
                m = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                send(m, 8'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            drain();
            check(gi, "queue_empty_at_end", exp_q.size(), 0);
            mark_done();
        end
    end

    initial begin
        for (int c = 0; c < 80000 && done_cnt < NCFG; c++) @(posedge clk);
        if (done_cnt < NCFG) begin
            n_checks++;
            n_fail++;
            $display("FAIL global_timeout: got %0d configs done, expected %0d", done_cnt, NCFG);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
